// File: rtl/timer_pkg.sv
// Shared definitions for the two-channel timer datapath.
package timer_pkg;

    localparam int CNT_BW = 32;

    typedef enum logic {
        TICK_SRC_PRESCALER = 1'b0,
        TICK_SRC_CASCADE   = 1'b1
    } tick_src_e;

endpackage

// File: rtl/timer_channel.sv
// One counter channel: enable edge detect, up/down counter with reload,
// compare-match detection and a registered one-cycle match pulse.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_BW_p = CNT_BW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                tick,
    input  logic                reload,
    input  logic                count_up,
    input  logic [CNT_BW_p-1:0] load_value,
    input  logic [CNT_BW_p-1:0] compare_value,
    output logic [CNT_BW_p-1:0] value,
    output logic                match_evt,
    output logic                match
);

    localparam logic [CNT_BW_p-1:0] ONE_C = {{(CNT_BW_p-1){1'b0}}, 1'b1};

    logic                en_q_r;
    logic [CNT_BW_p-1:0] value_r;
    logic                match_r;
    logic                match_evt_s;
    logic [CNT_BW_p-1:0] value_nxt_s;

    // Match detection and next-value selection in priority order
    always_comb begin
        match_evt_s = en && en_q_r && tick && (value_r == compare_value);
        value_nxt_s = value_r;
        if (!en) begin
            value_nxt_s = value_r;
        end else if (!en_q_r) begin
            value_nxt_s = load_value;
        end else if (tick) begin
            if (match_evt_s && reload) begin
                value_nxt_s = load_value;
            end else if (count_up) begin
                value_nxt_s = value_r + ONE_C;
            end else begin
                value_nxt_s = value_r - ONE_C;
            end
        end else begin
            value_nxt_s = value_r;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q_r  <= 1'b0;
            value_r <= {CNT_BW_p{1'b0}};
            match_r <= 1'b0;
        end else begin
            en_q_r  <= en;
            value_r <= value_nxt_s;
            match_r <= match_evt_s;
        end
    end

    assign value     = value_r;
    assign match_evt = match_evt_s;
    assign match     = match_r;

endmodule

// File: rtl/timer_core.sv
// Two-channel timer: shared prescaler, CNT0 plus CNT1 with selectable
// prescaled or cascaded (CNT0 match) tick source.
module timer_core
    import timer_pkg::*;
#(
    parameter int CNT_BW_p   = CNT_BW,
    parameter int TICK_DIV_p = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cnt0_en,
    input  logic                i_cnt0_reload,
    input  logic                i_cnt0_count_up,
    input  logic [CNT_BW_p-1:0] i_cnt0_load_value,
    input  logic [CNT_BW_p-1:0] i_cnt0_compare_value,
    output logic [CNT_BW_p-1:0] o_cnt0_value,
    output logic                o_cnt0_match,
    input  logic                i_cnt1_en,
    input  logic                i_cnt1_reload,
    input  logic                i_cnt1_count_up,
    input  logic [CNT_BW_p-1:0] i_cnt1_load_value,
    input  logic [CNT_BW_p-1:0] i_cnt1_compare_value,
    input  logic                i_cnt1_src,
    output logic [CNT_BW_p-1:0] o_cnt1_value,
    output logic                o_cnt1_match
);

    localparam int              PRE_W       = (TICK_DIV_p > 1) ? $clog2(TICK_DIV_p) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX_C  = PRE_W'(TICK_DIV_p - 1);
    localparam logic [PRE_W-1:0] PRE_ONE_C  = PRE_W'(1);

    logic [PRE_W-1:0] presc_r;
    logic             tick_s;
    tick_src_e        src_r;
    logic             cnt0_evt_s;
    logic             cnt1_tick_s;

    assign tick_s = (presc_r == PRE_MAX_C);

    // Free-running prescaler and registered CNT1 source select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= {PRE_W{1'b0}};
            src_r   <= TICK_SRC_PRESCALER;
        end else begin
            presc_r <= tick_s ? {PRE_W{1'b0}} : (presc_r + PRE_ONE_C);
            src_r   <= tick_src_e'(i_cnt1_src);
        end
    end

    // Cascade uses the CNT0 match event of the same cycle, bypassing the prescaler
    always_comb begin
        cnt1_tick_s = tick_s;
        case (src_r)
            TICK_SRC_CASCADE:   cnt1_tick_s = cnt0_evt_s;
            TICK_SRC_PRESCALER: cnt1_tick_s = tick_s;
            default:            cnt1_tick_s = tick_s;
        endcase
    end

    timer_channel #(.CNT_BW_p(CNT_BW_p)) u_cnt0 (
        .clk           (clk),
        .rst           (rst),
        .en            (i_cnt0_en),
        .tick          (tick_s),
        .reload        (i_cnt0_reload),
        .count_up      (i_cnt0_count_up),
        .load_value    (i_cnt0_load_value),
        .compare_value (i_cnt0_compare_value),
        .value         (o_cnt0_value),
        .match_evt     (cnt0_evt_s),
        .match         (o_cnt0_match)
    );

    timer_channel #(.CNT_BW_p(CNT_BW_p)) u_cnt1 (
        .clk           (clk),
        .rst           (rst),
        .en            (i_cnt1_en),
        .tick          (cnt1_tick_s),
        .reload        (i_cnt1_reload),
        .count_up      (i_cnt1_count_up),
        .load_value    (i_cnt1_load_value),
        .compare_value (i_cnt1_compare_value),
        .value         (o_cnt1_value),
        .match_evt     (),
        .match         (o_cnt1_match)
    );

endmodule
